mul_div_unit: RTL
=================

Name: mul_div_unit

Overview:
- Multicycle arithmetic responder for the SAP-1 datapath.
- Executes the MUL and DIV steps issued by the controller's multiplier-enable and divider-enable control signals.
- Captures the A and B register contents, computes iteratively (shift-add multiply, restoring divide) and reports completion with busy/done.
- Drives its result onto the shared bus when output-enabled, so the controller can load it into A.

Parameters:
WIDTH, 8, operand/result width in bits (bus width)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
a_in  input  WIDTH  A register value (multiplicand / dividend)
b_in  input  WIDTH  B register value (multiplier / divisor)
mul_start  input  1  controller multiplier-enable; request multiply
div_start  input  1  controller divider-enable; request divide
out_en  input  1  drive result onto bus_out
bus_out  output  WIDTH  out_en ? result : 0 (combinational)
result  output  WIDTH  product low bits or quotient, registered
remainder  output  WIDTH  divide remainder, registered (0 after multiply)
busy  output  1  operation in progress
done  output  1  one-cycle completion pulse
overflow  output  1  multiply product exceeded WIDTH bits
div_by_zero  output  1  last divide had b_in == 0

Behaviour:
- Reset (async, any time, including mid-operation): state IDLE; result, remainder, counter and internal accumulators 0; busy, done, overflow, div_by_zero 0. Computation in flight is discarded.
- States: IDLE, MUL, DIV, DONE. busy = 1 exactly in MUL or DIV.
- Start acceptance: sampled only in IDLE or DONE.
  - a_in and b_in are captured on the same edge.
  - mul_start and div_start both high: multiply wins, divide request dropped.
  - Starts while busy are ignored, with no queuing.
  - overflow and div_by_zero clear on acceptance of any new start.
- MUL:
  - WIDTH iteration cycles, one multiplier bit per cycle, LSB first; 2*WIDTH-bit accumulator.
  - After the WIDTH-th iteration edge: state DONE; result = product[WIDTH-1:0]; remainder = 0; overflow = (product[2W-1:W] != 0).
- DIV (b != 0):
  - WIDTH iterations of restoring division, MSB first: shift remainder left with the next dividend bit, trial-subtract divisor, set quotient bit if no borrow.
  - After the WIDTH-th edge: state DONE; result = quotient; remainder = remainder.
- DIV with b == 0: no iterations. The accept edge goes directly to DONE with result = all ones, remainder = a_in, div_by_zero = 1.
- DONE: done = 1 for exactly one cycle. Next state is IDLE, or MUL/DIV if a new start is accepted that cycle.
- Latency (start sampled at edge k):
  - Normal operation: done high in the cycle after edge k+WIDTH, i.e. WIDTH+1 cycles after start.
  - Divide by zero: done high in the cycle after edge k.
- Result hold: result, remainder and flags hold until the next accepted start or reset. They are not modified while busy; intermediate values live in internal registers only.
- bus_out is independent of state. With out_en asserted while busy, bus_out shows the previous held result.
- All arithmetic is unsigned. The iteration counter is ceil(log2(WIDTH+1)) bits and does not wrap within an operation.

Test Plan:
- Reset, then mul_start with a=13, b=11 (WIDTH=8) -> busy high for 8 cycles; done pulse in the 9th cycle after start; result=0x8F, remainder=0, overflow=0. With out_en=1, bus_out=0x8F.
- mul_start with a=20, b=20 -> result=0x90, overflow=1; then mul 255*1 -> result=0xFF, overflow cleared to 0.
- div_start with a=200, b=7 -> result=28, remainder=4 after 9 cycles. Then a=5, b=9 -> result=0, remainder=5.
- div_start with a=5, b=0 -> done in the next cycle; result=0xFF, remainder=5, div_by_zero=1, busy never asserted.
- Precedence and ignore rules:
  - mul_start and div_start together with a=6, b=3 -> result=18 (multiply taken).
  - mul_start pulsed again mid-operation with different operands -> ignored; original result delivered.
  - New start in the DONE cycle -> accepted; busy next cycle.
- Reset asserted asynchronously at iteration 4 of a divide -> all outputs 0 immediately; no done pulse; a subsequent mul 3*4 -> result=12.

Source files
------------

// File: rtl/mul_div_unit.sv
// mul_div_unit: multicycle unsigned multiply / divide responder for the SAP-1 bus.
// Shift-add multiply (LSB first) and restoring divide (MSB first), one bit per cycle.
// Results and flags are held until the next accepted start; bus_out drives the held
// result when out_en is asserted.
module mul_div_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             mul_start,
    input  logic             div_start,
    input  logic             out_en,
    output logic [WIDTH-1:0] bus_out,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt;
    // MUL: {partial product high, remaining multiplier bits}
    // DIV: {partial remainder, dividend bits shifting out / quotient bits shifting in}
    logic [2*WIDTH-1:0]   acc, acc_nxt;
    logic [WIDTH-1:0]     opnd;       // multiplicand or divisor
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_diff;
    logic                 div_ge;
    logic                 accept;
    logic                 last_iter;

    assign accept    = ((state == IDLE) || (state == DONE)) && (mul_start || div_start);
    assign last_iter = (cnt == CW'(WIDTH - 1));
    assign bus_out   = out_en ? result : '0;

    // One iteration step of either algorithm
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} +
                    (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        // The partial remainder is always below the divisor, so bit WIDTH of the
        // difference is set exactly when the trial subtraction borrows.
        div_ge    = ~div_diff[WIDTH];
        acc_nxt   = acc;
        case (state)
            MUL:     acc_nxt = {mul_sum, acc[WIDTH-1:1]};
            DIV:     acc_nxt = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                                acc[WIDTH-2:0], div_ge};
            default: acc_nxt = acc;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; multiply wins when both starts are high
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (mul_start)      state_nxt = MUL;
                else if (div_start) state_nxt = (b_in == '0) ? DONE : DIV;
                else                state_nxt = IDLE;
            end
            MUL, DIV:   state_nxt = last_iter ? DONE : state;
            default:    state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        busy = (state == MUL) || (state == DIV);
        done = (state == DONE);
    end

    // Operand capture, iteration and result/flag update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            acc         <= '0;
            opnd        <= '0;
            result      <= '0;
            remainder   <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            cnt         <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
            if (mul_start) begin
                acc  <= {{WIDTH{1'b0}}, b_in};
                opnd <= a_in;
            end else begin
                acc  <= {{WIDTH{1'b0}}, a_in};
                opnd <= b_in;
                if (b_in == '0) begin
                    result      <= '1;
                    remainder   <= a_in;
                    div_by_zero <= 1'b1;
                end
            end
        end else if (busy) begin
            acc <= acc_nxt;
            if (!last_iter) cnt <= cnt + 1'b1;
            if (last_iter) begin
                result <= acc_nxt[WIDTH-1:0];
                if (state == MUL) begin
                    remainder <= '0;
                    overflow  <= |acc_nxt[2*WIDTH-1:WIDTH];
                end else begin
                    remainder <= acc_nxt[2*WIDTH-1:WIDTH];
                end
            end
        end
    end

endmodule
